// File: rtl/logic_sweep_unit.sv
// Registered WIDTH-bit logic unit with eight selectable functions and a built-in
// truth-table sweeper that counts how many operand combinations produce all ones.
module logic_sweep_unit #(
   parameter int WIDTH       = 4,
   parameter int HOLD_CYCLES = 50
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2:0]         op,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   input  logic               start,
   input  logic               abort,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   output logic [WIDTH-1:0]   y,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH:0]   match_count
);

   localparam int VW = 2 * WIDTH;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWEEP  = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [2:0]      op_q;
   logic [2:0]      op_eff;
   logic [VW-1:0]   v;
   logic [HW-1:0]   h;
   logic [WIDTH-1:0] f_now;
   logic            hold_end;
   logic            last_vec;
   logic            is_match;

   function automatic logic [WIDTH-1:0] logic_fn(
      input logic [2:0]       sel,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [WIDTH-1:0] r;
      case (sel)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a ^ b;
         3'b011:  r = ~(a & b);
         3'b100:  r = ~(a | b);
         3'b101:  r = ~(a ^ b);
         3'b110:  r = a;
         default: r = ~a;
      endcase
      return r;
   endfunction

   // The function is latched at sweep start so a wiggling op switch cannot corrupt the count.
   assign op_eff   = (state == IDLE) ? op : op_q;
   assign f_now    = logic_fn(op_eff, a_out, b_out);
   assign hold_end = (state == SWEEP) && (h == HOLD_LAST);
   assign last_vec = &v;
   assign is_match = hold_end && (f_now == {WIDTH{1'b1}});

   assign busy = (state == SWEEP);
   assign done = (state == FINISH);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SWEEP;
            end
         end
         SWEEP: begin
            if (abort) begin
               state_next = IDLE;
            end else if (hold_end && last_vec) begin
               state_next = FINISH;
            end
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The vector counter stops at all ones, so FINISH keeps displaying the last vector.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q        <= 3'b000;
         v           <= '0;
         h           <= '0;
         a_out       <= '0;
         b_out       <= '0;
         y           <= '0;
         match_count <= '0;
      end else begin
         y <= f_now;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q        <= op;
                  v           <= '0;
                  h           <= '0;
                  a_out       <= '0;
                  b_out       <= '0;
                  match_count <= '0;
               end else begin
                  a_out <= a_in;
                  b_out <= b_in;
               end
            end
            SWEEP: begin
               if (is_match) begin
                  match_count <= match_count + 1'b1;
               end
               if (hold_end) begin
                  h <= '0;
                  if (!last_vec) begin
                     v              <= v + 1'b1;
                     {a_out, b_out} <= v + 1'b1;
                  end
               end else begin
                  h <= h + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logic_sweep_unit.sv
// Directed bench for logic_sweep_unit: four instances cover the narrow sweeps,
// the abort path and the 4-bit manual path with hand-computed expectations.
module tb_logic_sweep_unit;

   logic clk = 1'b0;
   logic rst_n;

   logic [2:0] op_1, op_2, op_4, op_a;
   logic [0:0] a_in_1, b_in_1, a_out_1, b_out_1, y_1;
   logic [1:0] a_in_2, b_in_2, a_out_2, b_out_2, y_2;
   logic [3:0] a_in_4, b_in_4, a_out_4, b_out_4, y_4;
   logic [0:0] a_in_a, b_in_a, a_out_a, b_out_a, y_a;
   logic start_1, start_2, start_4, start_a;
   logic abort_1, abort_2, abort_4, abort_a;
   logic busy_1, busy_2, busy_4, busy_a;
   logic done_1, done_2, done_4, done_a;
   logic [2:0] match_count_1;
   logic [4:0] match_count_2;
   logic [8:0] match_count_4;
   logic [2:0] match_count_a;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   logic_sweep_unit #(.WIDTH(1), .HOLD_CYCLES(2)) u_w1 (
      .clk(clk), .rst_n(rst_n), .op(op_1), .a_in(a_in_1), .b_in(b_in_1),
      .start(start_1), .abort(abort_1), .a_out(a_out_1), .b_out(b_out_1),
      .y(y_1), .busy(busy_1), .done(done_1), .match_count(match_count_1));

   logic_sweep_unit #(.WIDTH(2), .HOLD_CYCLES(1)) u_w2 (
      .clk(clk), .rst_n(rst_n), .op(op_2), .a_in(a_in_2), .b_in(b_in_2),
      .start(start_2), .abort(abort_2), .a_out(a_out_2), .b_out(b_out_2),
      .y(y_2), .busy(busy_2), .done(done_2), .match_count(match_count_2));

   logic_sweep_unit #(.WIDTH(4), .HOLD_CYCLES(50)) u_w4 (
      .clk(clk), .rst_n(rst_n), .op(op_4), .a_in(a_in_4), .b_in(b_in_4),
      .start(start_4), .abort(abort_4), .a_out(a_out_4), .b_out(b_out_4),
      .y(y_4), .busy(busy_4), .done(done_4), .match_count(match_count_4));

   logic_sweep_unit #(.WIDTH(1), .HOLD_CYCLES(4)) u_ab (
      .clk(clk), .rst_n(rst_n), .op(op_a), .a_in(a_in_a), .b_in(b_in_a),
      .start(start_a), .abort(abort_a), .a_out(a_out_a), .b_out(b_out_a),
      .y(y_a), .busy(busy_a), .done(done_a), .match_count(match_count_a));

   function automatic logic [7:0] model_f(input logic [2:0] sel, input logic [7:0] a,
                                          input logic [7:0] b, input int w);
      logic [7:0] r;
      logic [7:0] mask;
      mask = 8'hFF >> (8 - w);
      case (sel)
         3'd0:    r = a & b;
         3'd1:    r = a | b;
         3'd2:    r = a ^ b;
         3'd3:    r = ~(a & b);
         3'd4:    r = ~(a | b);
         3'd5:    r = ~(a ^ b);
         3'd6:    r = a;
         default: r = ~a;
      endcase
      return r & mask;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      start_1 = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy_1, done_1, a_out_1, b_out_1, y_1, match_count_1} !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs got %b expected 00000000",
                  {busy_1, done_1, a_out_1, b_out_1, y_1, match_count_1});
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy_1 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_release_start got busy=%b expected 1", busy_1);
      end
      start_1 = 1'b0;
      abort_1 = 1'b1;
      @(negedge clk);
      abort_1 = 1'b0;
      vectors++;
      if (busy_1 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_abort_cleanup got busy=%b expected 0", busy_1);
      end
   endtask

   task automatic test_sweep_w1(input logic [2:0] f, input int exp_match);
      int cnt;
      logic [1:0] vec;
      logic [7:0] t;
      @(negedge clk);
      op_1 = f;
      start_1 = 1'b1;
      @(negedge clk);
      start_1 = 1'b0;
      cnt = 0;
      while (busy_1 && cnt < 64) begin
         vec = 2'(cnt / 2);
         vectors++;
         if ({a_out_1, b_out_1} !== vec) begin
            miscompares++;
            $display("[TB] FAIL w1_operands op=%0d cycle=%0d got %b expected %b",
                     f, cnt, {a_out_1, b_out_1}, vec);
         end
         if (cnt % 2 == 1) begin
            t = model_f(f, {7'b0, vec[1]}, {7'b0, vec[0]}, 1);
            vectors++;
            if (y_1 !== t[0]) begin
               miscompares++;
               $display("[TB] FAIL w1_y op=%0d cycle=%0d got %b expected %b", f, cnt, y_1, t[0]);
            end
         end
         cnt++;
         @(negedge clk);
      end
      vectors++;
      if (cnt !== 8 || done_1 !== 1'b1 || match_count_1 !== 3'(exp_match)) begin
         miscompares++;
         $display("[TB] FAIL w1_sweep op=%0d got busy_cycles=%0d done=%b count=%0d expected 8 1 %0d",
                  f, cnt, done_1, match_count_1, exp_match);
      end
      @(negedge clk);
      vectors++;
      if (done_1 !== 1'b0 || busy_1 !== 1'b0 || match_count_1 !== 3'(exp_match)) begin
         miscompares++;
         $display("[TB] FAIL w1_after op=%0d got done=%b busy=%b count=%0d expected 0 0 %0d",
                  f, done_1, busy_1, match_count_1, exp_match);
      end
   endtask

   task automatic test_sweep_w2(input logic [2:0] f, input int exp_match, input bit toggle);
      int cnt;
      logic [3:0] vec;
      logic [3:0] prev;
      logic [7:0] t;
      @(negedge clk);
      op_2 = f;
      start_2 = 1'b1;
      @(negedge clk);
      start_2 = 1'b0;
      cnt = 0;
      prev = 4'h0;
      while (busy_2 && cnt < 64) begin
         vec = 4'(cnt);
         vectors++;
         if ({a_out_2, b_out_2} !== vec) begin
            miscompares++;
            $display("[TB] FAIL w2_operands op=%0d cycle=%0d got %h expected %h",
                     f, cnt, {a_out_2, b_out_2}, vec);
         end
         if (cnt > 0) begin
            t = model_f(f, {6'b0, prev[3:2]}, {6'b0, prev[1:0]}, 2);
            vectors++;
            if (y_2 !== t[1:0]) begin
               miscompares++;
               $display("[TB] FAIL w2_y op=%0d cycle=%0d got %h expected %h", f, cnt, y_2, t[1:0]);
            end
         end
         if (toggle) op_2 = 3'(cnt);
         prev = vec;
         cnt++;
         @(negedge clk);
      end
      op_2 = f;
      vectors++;
      if (cnt !== 16 || done_2 !== 1'b1 || match_count_2 !== 5'(exp_match)) begin
         miscompares++;
         $display("[TB] FAIL w2_sweep op=%0d got busy_cycles=%0d done=%b count=%0d expected 16 1 %0d",
                  f, cnt, done_2, match_count_2, exp_match);
      end
      @(negedge clk);
   endtask

   task automatic test_manual();
      @(negedge clk);
      a_in_4 = 4'hC;
      b_in_4 = 4'hA;
      op_4 = 3'b000;
      @(negedge clk);
      vectors++;
      if (a_out_4 !== 4'hC || b_out_4 !== 4'hA) begin
         miscompares++;
         $display("[TB] FAIL manual_operands got %h %h expected c a", a_out_4, b_out_4);
      end
      @(negedge clk);
      vectors++;
      if (y_4 !== 4'h8 || busy_4 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL manual_and got y=%h busy=%b expected 8 0", y_4, busy_4);
      end
      op_4 = 3'b010;
      @(negedge clk);
      vectors++;
      if (y_4 !== 4'h6) begin
         miscompares++;
         $display("[TB] FAIL manual_xor got %h expected 6", y_4);
      end
      op_4 = 3'b111;
      @(negedge clk);
      vectors++;
      if (y_4 !== 4'h3) begin
         miscompares++;
         $display("[TB] FAIL manual_not_a got %h expected 3", y_4);
      end
      a_in_4 = 4'h5;
      b_in_4 = 4'h3;
      op_4 = 3'b100;
      repeat (2) @(negedge clk);
      vectors++;
      if (y_4 !== 4'h8) begin
         miscompares++;
         $display("[TB] FAIL manual_nor got %h expected 8", y_4);
      end
   endtask

   // abort_cycle < 0 lets the sweep run to completion.
   task automatic test_abort(input int abort_cycle, input int exp_match);
      int cnt;
      logic exp_done;
      exp_done = (abort_cycle < 0);
      @(negedge clk);
      op_a = 3'b001;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      vectors++;
      if (match_count_a !== 3'd0 || busy_a !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL abort_start got count=%0d busy=%b expected 0 1", match_count_a, busy_a);
      end
      cnt = 0;
      while (busy_a && cnt < 64) begin
         abort_a = (cnt == abort_cycle);
         cnt++;
         @(negedge clk);
      end
      abort_a = 1'b0;
      vectors++;
      if (cnt !== (exp_done ? 16 : abort_cycle + 1) || done_a !== exp_done ||
          match_count_a !== 3'(exp_match)) begin
         miscompares++;
         $display("[TB] FAIL abort_result at=%0d got cycles=%0d done=%b count=%0d expected %0d %b %0d",
                  abort_cycle, cnt, done_a, match_count_a, exp_done ? 16 : abort_cycle + 1,
                  exp_done, exp_match);
      end
      @(negedge clk);
      vectors++;
      if (done_a !== 1'b0 || match_count_a !== 3'(exp_match)) begin
         miscompares++;
         $display("[TB] FAIL abort_hold got done=%b count=%0d expected 0 %0d",
                  done_a, match_count_a, exp_match);
      end
   endtask

   task automatic test_back_to_back();
      int cnt;
      @(negedge clk);
      op_1 = 3'b000;
      start_1 = 1'b1;
      @(negedge clk);
      cnt = 0;
      while (busy_1 && cnt < 64) begin
         cnt++;
         @(negedge clk);
      end
      vectors++;
      if (cnt !== 8 || done_1 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL b2b_first got cycles=%0d done=%b expected 8 1", cnt, done_1);
      end
      @(negedge clk);
      vectors++;
      if (busy_1 !== 1'b0 || done_1 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL b2b_idle_gap got busy=%b done=%b expected 0 0", busy_1, done_1);
      end
      @(negedge clk);
      start_1 = 1'b0;
      vectors++;
      if (busy_1 !== 1'b1 || match_count_1 !== 3'd0 || {a_out_1, b_out_1} !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL b2b_restart got busy=%b count=%0d ops=%b expected 1 0 00",
                  busy_1, match_count_1, {a_out_1, b_out_1});
      end
      cnt = 0;
      while (busy_1 && cnt < 64) begin
         cnt++;
         @(negedge clk);
      end
      vectors++;
      if (cnt !== 8 || done_1 !== 1'b1 || match_count_1 !== 3'd1) begin
         miscompares++;
         $display("[TB] FAIL b2b_second got cycles=%0d done=%b count=%0d expected 8 1 1",
                  cnt, done_1, match_count_1);
      end
      @(negedge clk);
   endtask

   task automatic test_start_abort_idle();
      @(negedge clk);
      start_1 = 1'b1;
      abort_1 = 1'b1;
      @(negedge clk);
      start_1 = 1'b0;
      vectors++;
      if (busy_1 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL start_abort_idle got busy=%b expected 1", busy_1);
      end
      @(negedge clk);
      abort_1 = 1'b0;
      vectors++;
      if (busy_1 !== 1'b0 || done_1 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL start_abort_then_abort got busy=%b done=%b expected 0 0", busy_1, done_1);
      end
   endtask

   task automatic test_reset_mid_sweep();
      @(negedge clk);
      op_1 = 3'b001;
      start_1 = 1'b1;
      @(negedge clk);
      start_1 = 1'b0;
      repeat (5) @(negedge clk);
      vectors++;
      if (busy_1 !== 1'b1 || match_count_1 !== 3'd1) begin
         miscompares++;
         $display("[TB] FAIL mid_sweep_progress got busy=%b count=%0d expected 1 1", busy_1, match_count_1);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      vectors++;
      if ({busy_1, done_1, a_out_1, b_out_1, y_1, match_count_1} !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL mid_sweep_reset got %b expected 00000000",
                  {busy_1, done_1, a_out_1, b_out_1, y_1, match_count_1});
      end
      repeat (2) @(negedge clk);
      vectors++;
      if (done_1 !== 1'b0 || busy_1 !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL mid_sweep_no_done got done=%b busy=%b expected 0 0", done_1, busy_1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      {op_1, op_2, op_4, op_a} = '0;
      {a_in_1, b_in_1, a_in_2, b_in_2, a_in_4, b_in_4, a_in_a, b_in_a} = '0;
      {start_1, start_2, start_4, start_a} = '0;
      {abort_1, abort_2, abort_4, abort_a} = '0;
      test_reset();
      test_sweep_w1(3'b000, 1);
      test_sweep_w1(3'b001, 3);
      test_sweep_w1(3'b011, 3);
      test_sweep_w1(3'b100, 1);
      test_sweep_w1(3'b010, 2);
      test_sweep_w1(3'b101, 2);
      test_sweep_w2(3'b010, 4, 1'b0);
      test_sweep_w2(3'b111, 4, 1'b0);
      test_sweep_w2(3'b110, 4, 1'b0);
      test_sweep_w2(3'b010, 4, 1'b1);
      test_manual();
      test_abort(9, 1);
      test_abort(11, 2);
      test_abort(-1, 3);
      test_back_to_back();
      test_start_abort_idle();
      test_reset_mid_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
